// File: rtl/mux_pkg.sv
// mux_pkg: shared types, sizes and round-robin pick helper for the 4:1 stream mux.
package mux_pkg;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    // Returns {found, idx}: first valid channel searched upward from ptr+1, wrapping.
    function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0] valid, input logic [SELW-1:0] ptr);
        logic [SELW-1:0] c;
        rr_pick = '0;
        for (int k = NCH; k >= 1; k--) begin
            c = ptr + SELW'(k);
            if (valid[c]) rr_pick = {1'b1, c};
        end
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational round-robin picker over four request lines.
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NCH-1:0]  valid,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [SELW-1:0] idx
);

    logic found;

    assign {found, idx} = rr_pick(valid, ptr);
    assign gnt_onehot   = found ? NCH'(1) << idx : '0;

endmodule

// File: rtl/mux_rr_4to1.sv
// mux_rr_4to1: registered 4:1 valid/ready stream mux with round-robin arbitration
// and packet locking; each output beat carries its source channel in Y_SEL.
module mux_rr_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       IN_VALID,
    output logic [NCH-1:0]       IN_READY,
    input  logic [NCH*WIDTH-1:0] IN_DATA,
    input  logic [NCH-1:0]       IN_LAST,
    output logic                 Y_VALID,
    input  logic                 Y_READY,
    output logic [WIDTH-1:0]     Y,
    output logic                 Y_LAST,
    output logic [SELW-1:0]      Y_SEL
);

    state_t          state, state_n;
    logic [SELW-1:0] ptr, ptr_n, owner, owner_n, gidx;
    logic [NCH-1:0]  arb_valid, gnt;
    logic            load_en, fire, last;

    // While locked, masking everything but the owner makes the picker select it alone.
    assign arb_valid = (state == LOCK) ? IN_VALID & (NCH'(1) << owner) : IN_VALID;

    rr_arb4 u_arb (
        .valid      (arb_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt),
        .idx        (gidx)
    );

    assign load_en  = !Y_VALID || Y_READY;
    assign IN_READY = gnt & {NCH{load_en}};
    assign fire     = |IN_READY;
    assign last     = IN_LAST[gidx];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        if (fire && last) begin
            ptr_n   = gidx;
            state_n = ARB;
        end else if (fire && state == ARB) begin
            owner_n = gidx;
            state_n = LOCK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ARB;
            ptr     <= SELW'(NCH - 1);
            owner   <= '0;
            Y_VALID <= 1'b0;
            Y       <= '0;
            Y_LAST  <= 1'b0;
            Y_SEL   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            if (load_en) begin
                Y_VALID <= fire;
                if (fire) begin
                    Y      <= IN_DATA[gidx*WIDTH +: WIDTH];
                    Y_LAST <= last;
                    Y_SEL  <= gidx;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_4to1.sv
// tb_mux_rr_4to1: directed test-plan steps plus randomized traffic, checked each
// cycle against a behavioural model of the arbiter and output register.
module tb_mux_rr_4to1;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic [3:0]     IN_VALID;
    logic [3:0]     IN_READY;
    logic [4*W-1:0] IN_DATA;
    logic [3:0]     IN_LAST;
    logic           Y_VALID;
    logic           Y_READY;
    logic [W-1:0]   Y;
    logic           Y_LAST;
    logic [1:0]     Y_SEL;

    mux_rr_4to1 #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_DATA  (IN_DATA),
        .IN_LAST  (IN_LAST),
        .Y_VALID  (Y_VALID),
        .Y_READY  (Y_READY),
        .Y        (Y),
        .Y_LAST   (Y_LAST),
        .Y_SEL    (Y_SEL)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: priority pointer, lock owner, and the output beat.
    int       m_ptr, m_owner;
    bit       m_locked;
    bit       e_valid, e_last;
    int       e_sel;
    logic [7:0] e_y;
    logic [3:0] acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 3; m_owner = 0; m_locked = 0;
        e_valid = 0; e_last = 0; e_sel = 0; e_y = 8'h00;
    endtask

    task automatic set_ch(input int i, input bit v, input logic [7:0] d, input bit l);
        IN_VALID[i] = v;
        IN_DATA[i*W +: W] = d;
        IN_LAST[i] = l;
    endtask

    // One clock: check the combinational accept, clock, then check the registered beat.
    task automatic step();
        int  g;
        bit  load;
        logic [3:0] exp_rdy;
        #1;
        load = !e_valid || Y_READY;
        g = -1;
        if (m_locked) g = IN_VALID[m_owner] ? m_owner : -1;
        else
            for (int k = 1; k <= 4 && g < 0; k++)
                if (IN_VALID[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
        acc = exp_rdy;
        @(posedge CLK);
        #1;
        if (RST) model_reset();
        else if (load) begin
            e_valid = (g >= 0);
            if (g >= 0) begin
                e_y = IN_DATA[g*W +: W];
                e_last = IN_LAST[g];
                e_sel = g;
                if (e_last) begin
                    m_ptr = g; m_locked = 0;
                end else if (!m_locked) begin
                    m_locked = 1; m_owner = g;
                end
            end
        end
        chk("y_valid", 32'(Y_VALID), 32'(e_valid));
        chk("y", 32'(Y), 32'(e_y));
        chk("y_last", 32'(Y_LAST), 32'(e_last));
        chk("y_sel", 32'(Y_SEL), 32'(e_sel));
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; IN_VALID = '0; IN_DATA = '0; IN_LAST = '0; Y_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        model_reset();
        step();
        chk("reset_y_valid", 32'(Y_VALID), 32'd0);
        RST = 1'b0;

        // Round robin over four always-valid single-beat channels.
        for (int i = 0; i < 4; i++) set_ch(i, 1, 8'(8'h10 + i), 1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_sel", 32'(Y_SEL), 32'(k % 4));
            chk("rr_valid", 32'(Y_VALID), 32'd1);
        end

        // Channel 2 packet A0..A2 stays contiguous, then channel 3 is next.
        for (int b = 0; b < 3; b++) begin
            set_ch(2, 1, 8'(8'hA0 + b), b == 2);
            step();
            chk("pkt_y", 32'(Y), 32'(8'hA0 + b));
            chk("pkt_sel", 32'(Y_SEL), 32'd2);
            chk("pkt_last", 32'(Y_LAST), 32'(b == 2));
        end
        set_ch(2, 1, 8'h12, 1);
        step();
        chk("after_pkt_sel", 32'(Y_SEL), 32'd3);

        // Stall: hold 0x55 for four cycles, then the next beat follows with no gap.
        IN_VALID = '0;
        set_ch(0, 1, 8'h55, 1);
        step();
        chk("stall_load", 32'(Y), 32'h55);
        set_ch(0, 0, 8'h00, 1);
        set_ch(1, 1, 8'h66, 1);
        Y_READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_hold", 32'(Y), 32'h55);
            chk("stall_rdy", 32'(IN_READY), 32'd0);
        end
        Y_READY = 1'b1;
        step();
        chk("stall_next", 32'(Y), 32'h66);
        chk("stall_next_v", 32'(Y_VALID), 32'd1);

        // Channel 1 alone, Y_READY toggling; beats held until accepted.
        for (int k = 0; k < 8; k++) begin
            Y_READY = (k % 2 == 0);
            if (acc[1]) set_ch(1, 1, 8'($urandom), 1);
            step();
        end
        Y_READY = 1'b1;
        IN_VALID = '0;
        step();

        // Lock on channel 0, owner goes idle, channel 3 must wait.
        set_ch(0, 1, 8'hC0, 0);
        step();
        set_ch(0, 0, 8'hC1, 0);
        set_ch(3, 1, 8'h33, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("lock_wait_rdy", 32'(IN_READY), 32'd0);
        end
        set_ch(0, 1, 8'hC1, 1);
        step();
        chk("lock_end_sel", 32'(Y_SEL), 32'd0);
        set_ch(0, 0, 8'h00, 0);
        step();
        chk("lock_then_3", 32'(Y_SEL), 32'd3);

        // Reset during LOCK with a stalled beat held.
        IN_VALID = '0;
        set_ch(1, 1, 8'hD0, 0);
        step();
        Y_READY = 1'b0;
        set_ch(1, 0, 8'hD1, 0);
        step();
        RST = 1'b1;
        step();
        chk("rst_valid", 32'(Y_VALID), 32'd0);
        chk("rst_sel", 32'(Y_SEL), 32'd0);
        RST = 1'b0;
        Y_READY = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 1, 8'(8'hE0 + i), 1);
        step();
        chk("rst_first", 32'(Y_SEL), 32'd0);

        // Random traffic with producers holding beats until accepted.
        IN_VALID = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++)
                if (!IN_VALID[i] || acc[i])
                    set_ch(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0);
            Y_READY = ($urandom_range(0, 3) != 0);
            RST = ($urandom_range(0, 99) == 0);
            step();
        end
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
